mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Control FSM for the serial multiply-accumulate datapath built from the team's 4-bit operand registers and 13-bit accumulator register.
- Computes sum of n_pairs products A*B over 4-bit unsigned pairs using shift-add, one multiplier bit per cycle.
- Drives all register write enables. Takes the multiplier LSB and zero status back from the datapath.
- Sits between the stream source (valid/ready) and the datapath. Reports busy/done to the top level.

Parameters:
- MAX_PAIRS, 32, maximum pairs per job; 32 x 255 = 8160 fits 13-bit accumulator.
- CNT_W, 6, width of n_pairs and the internal pair counter (must hold MAX_PAIRS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Synchronous, active-high; all state and outputs reset on the clk edge where rst=1.
- start  in  1  job request; sampled only in IDLE.
- n_pairs  in  CNT_W  pairs in job; latched with start. Values above MAX_PAIRS are clamped to MAX_PAIRS.
- in_valid  in  1  source presents an operand pair.
- in_ready  out  1  controller accepts a pair this cycle.
- b_lsb  in  1  LSB of datapath multiplier register.
- b_is_zero  in  1  datapath multiplier register == 0 (used only with optional feature).
- a_wr  out  1  write enable, multiplicand 4-bit reg.
- b_wr  out  1  write enable, multiplier 4-bit reg (load).
- b_shift  out  1  shift multiplier reg right by 1.
- p_clr  out  1  clear partial-product reg.
- p_add  out  1  partial product += A << bit_idx.
- bit_idx  out  2  current multiplier bit position.
- acc_clr  out  1  clear 13-bit accumulator.
- acc_wr  out  1  accumulator += partial product.
- busy  out  1  job in progress (any state except IDLE).
- done  out  1  one-cycle pulse when accumulator holds final sum.

Behaviour:
- Reset: state=IDLE, pair_cnt=0, n_lat=0, bit_idx=0. All outputs 0. rst mid-job aborts immediately; no done is issued.
- Outputs are Moore/registered-state decodes except in_ready/a_wr/b_wr/p_clr. Those are combinational on state and in_valid.
- IDLE:
  - start=1 with n_pairs=0: go to DONE and assert acc_clr this cycle.
  - start=1 otherwise: latch n_lat=min(n_pairs,MAX_PAIRS), pair_cnt=0, go to CLR.
- CLR: acc_clr=1 for one cycle -> WAIT_IN.
- WAIT_IN:
  - in_ready=1.
  - in_valid=1: a_wr=b_wr=p_clr=1, bit_idx<=0, go to MUL.
  - in_valid=0: stay.
- MUL:
  - Each cycle: p_add=b_lsb, b_shift=1, bit_idx<=bit_idx+1.
  - After the cycle with bit_idx=3, go to ACC.
  - bit_idx wraps 3->0 without side effect.
- ACC:
  - acc_wr=1 for one cycle, pair_cnt<=pair_cnt+1.
  - If pair_cnt+1==n_lat, go to DONE; else go to WAIT_IN.
- DONE: done=1 for one cycle -> IDLE. busy=1 in DONE, 0 in IDLE.
- start while busy: ignored, not queued.
- Latency with in_valid held high, counted from the start-sampling edge: done asserted in cycle 2+6n. For n=1 that is cycle 8. Each pair costs 6 cycles: load, 4 MUL, ACC.
- Only one of acc_clr/acc_wr asserted per cycle. p_clr and p_add are never both asserted.

Optional Feature:
- Macro: MAC_EARLY_TERM_EN.
- Defined:
  - In MUL, if b_is_zero=1 at the start of a cycle, go directly to ACC that cycle with p_add=0 and b_shift=0.
  - B=0 costs 1 MUL cycle.
  - B=1 costs 2 MUL cycles: bit 0 add, then zero detected.
- Undefined:
  - b_is_zero is ignored. MUL is always exactly 4 cycles.

Test Plan:
- rst=1 for 2 cycles mid-MUL -> next cycle all outputs 0, busy=0; a later start behaves as from reset.
- start, n_pairs=1, pair (A=15,B=15), in_valid held -> done at cycle 8, accumulator 225, p_add high on all 4 MUL cycles.
- start, n_pairs=32, all pairs (15,15) -> done at cycle 194, accumulator 7200, exactly 32 acc_wr pulses.
- n_pairs=3, pairs (3,5),(0,9),(7,2), in_valid deasserted 3 cycles between pairs -> in_ready held through gaps, final acc 29.
- n_pairs=0 -> acc_clr and DONE path; done at cycle 1, zero acc_wr pulses. n_pairs=40 -> exactly 32 pairs consumed.
- With MAC_EARLY_TERM_EN: n=1, (A=9,B=0) -> done at cycle 5, acc 0. (A=9,B=1) -> done at cycle 6, acc 9. Without the macro, both cases give done at cycle 8.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Control FSM for the serial shift-add multiply-accumulate datapath.
// Optional early termination on a zero multiplier: define MAC_EARLY_TERM_EN.
module mac_seq_ctrl #(
    parameter int unsigned MAX_PAIRS = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_pairs,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             b_lsb,
    input  logic             b_is_zero,
    output logic             a_wr,
    output logic             b_wr,
    output logic             b_shift,
    output logic             p_clr,
    output logic             p_add,
    output logic [1:0]       bit_idx,
    output logic             acc_clr,
    output logic             acc_wr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT_IN,
        S_MUL,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PAIRS);

    state_t           state, state_nx;
    logic [CNT_W-1:0] pair_cnt, pair_cnt_nx;
    logic [CNT_W-1:0] n_lat, n_lat_nx;
    logic [1:0]       bit_idx_nx;
    logic             early_exit;

`ifdef MAC_EARLY_TERM_EN
    assign early_exit = b_is_zero;
`else
    logic unused_b_is_zero;
    assign unused_b_is_zero = b_is_zero;
    assign early_exit       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pair_cnt <= '0;
            n_lat    <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_nx;
            pair_cnt <= pair_cnt_nx;
            n_lat    <= n_lat_nx;
            bit_idx  <= bit_idx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pair_cnt_nx = pair_cnt;
        n_lat_nx    = n_lat;
        bit_idx_nx  = bit_idx;
        in_ready    = 1'b0;
        a_wr        = 1'b0;
        b_wr        = 1'b0;
        b_shift     = 1'b0;
        p_clr       = 1'b0;
        p_add       = 1'b0;
        acc_clr     = 1'b0;
        acc_wr      = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    // An empty job still clears the accumulator so done reports a zero sum
                    if (n_pairs == '0) begin
                        acc_clr  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        n_lat_nx    = (n_pairs > MAX_P) ? MAX_P : n_pairs;
                        pair_cnt_nx = '0;
                        state_nx    = S_CLR;
                    end
                end
            end
            S_CLR: begin
                acc_clr  = 1'b1;
                state_nx = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_wr       = 1'b1;
                    b_wr       = 1'b1;
                    p_clr      = 1'b1;
                    bit_idx_nx = '0;
                    state_nx   = S_MUL;
                end
            end
            S_MUL: begin
                if (early_exit) begin
                    state_nx = S_ACC;
                end else begin
                    p_add      = b_lsb;
                    b_shift    = 1'b1;
                    bit_idx_nx = bit_idx + 2'd1;
                    if (bit_idx == 2'd3) state_nx = S_ACC;
                end
            end
            S_ACC: begin
                acc_wr      = 1'b1;
                pair_cnt_nx = pair_cnt + CNT_W'(1);
                state_nx    = (pair_cnt_nx == n_lat) ? S_DONE : S_WAIT_IN;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural 4-bit/13-bit datapath model.
// Expected done cycles follow MAC_EARLY_TERM_EN when it is defined for the build.
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_ready, b_lsb, b_is_zero;
    logic [5:0] n_pairs;
    logic       a_wr, b_wr, b_shift, p_clr, p_add, acc_clr, acc_wr, busy, done;
    logic [1:0] bit_idx;

    mac_seq_ctrl #(.MAX_PAIRS(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .n_pairs(n_pairs),
        .in_valid(in_valid), .in_ready(in_ready), .b_lsb(b_lsb), .b_is_zero(b_is_zero),
        .a_wr(a_wr), .b_wr(b_wr), .b_shift(b_shift), .p_clr(p_clr), .p_add(p_add),
        .bit_idx(bit_idx), .acc_clr(acc_clr), .acc_wr(acc_wr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Datapath model driven by the controller's enables
    logic [3:0]  a_in, b_in;
    logic [3:0]  a_reg = '0, b_reg = '0;
    logic [7:0]  p_reg = '0;
    logic [12:0] acc   = '0;
    assign b_lsb     = b_reg[0];
    assign b_is_zero = (b_reg == 4'd0);

    always @(posedge clk) begin
        if (a_wr) a_reg <= a_in;
        if (b_wr) b_reg <= b_in;
        else if (b_shift) b_reg <= b_reg >> 1;
        if (p_clr) p_reg <= '0;
        else if (p_add) p_reg <= p_reg + ({4'd0, a_reg} << bit_idx);
        if (acc_clr) acc <= '0;
        else if (acc_wr) acc <= acc + {5'd0, p_reg};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int acc;
        int cyc;
        int accwr;
        int padd;
    } exp_t;

    exp_t sb[$];
    int   pa[$];
    int   pb[$];
    int   tests = 0, fails = 0;
    int   job_id = 0, start_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle invariants and scoreboard pop on done
    initial begin
        int   seen_id = 0;
        int   accwr_cnt = 0, padd_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (seen_id != job_id) begin
                seen_id   = job_id;
                accwr_cnt = 0;
                padd_cnt  = 0;
            end
            if (!rst) begin
                if (acc_wr) accwr_cnt++;
                if (p_add) padd_cnt++;
                if (busy) begin
                    chk("acc_clr_and_acc_wr", int'(acc_clr & acc_wr), 0);
                    chk("p_clr_and_p_add", int'(p_clr & p_add), 0);
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("acc_value", int'(acc), e.acc);
                        if (e.cyc >= 0) chk("done_cycle", cyc - start_cyc + 1, e.cyc);
                        chk("acc_wr_pulses", accwr_cnt, e.accwr);
                        if (e.padd >= 0) chk("p_add_cycles", padd_cnt, e.padd);
                        chk("busy_in_done", int'(busy), 1);
                    end
                end
            end
        end
    end

    task automatic run_job(input int n, input int gap, input int exp_pairs, input int exp_acc,
                           input int exp_cyc, input int exp_accwr, input int exp_padd);
        exp_t e;
        int   idx = 0;
        bit   hs;
        e.acc = exp_acc; e.cyc = exp_cyc; e.accwr = exp_accwr; e.padd = exp_padd;
        sb.push_back(e);
        job_id++;
        start   = 1'b1;
        n_pairs = 6'(n);
        @(posedge clk); #1;
        start_cyc = cyc;
        start     = 1'b0;
        for (int t = 0; t < 1000 && sb.size() != 0; t++) begin
            if (idx < pa.size()) begin
                in_valid = 1'b1;
                a_in     = 4'(pa[idx]);
                b_in     = 4'(pb[idx]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (gap > 0 && idx < exp_pairs) begin
                    in_valid = 1'b0;
                    repeat (5) begin @(posedge clk); #1; end
                    for (int g = 0; g < gap; g++) begin
                        @(negedge clk);
                        chk("in_ready_in_gap", int'(in_ready), 1);
                        @(posedge clk); #1;
                    end
                end
            end
        end
        in_valid = 1'b0;
        chk("job_complete", sb.size(), 0);
        sb.delete();
        chk("pairs_consumed", idx, exp_pairs);
        @(negedge clk);
        chk("idle_after_job", int'(busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, int'({in_ready, a_wr, b_wr, b_shift, p_clr, p_add, bit_idx,
                        acc_clr, acc_wr, busy, done}), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_pairs = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_outputs_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        pa = {15}; pb = {15};
        run_job(1, 0, 1, 225, 8, 1, 4);

        pa.delete(); pb.delete();
        for (int i = 0; i < 32; i++) begin pa.push_back(15); pb.push_back(15); end
        run_job(32, 0, 32, 7200, 194, 32, 128);

        pa = {3, 0, 7}; pb = {5, 9, 2};
        run_job(3, 3, 3, 29, -1, 3, 5);

        pa.delete(); pb.delete();
        run_job(0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin pa.push_back(15); pb.push_back(15); end
        run_job(40, 0, 32, 7200, 194, 32, 128);

        // Abort mid-MUL: no done may follow, outputs clear on the first reset edge
        start = 1'b1; n_pairs = 6'd1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; a_in = 4'd15; b_in = 4'd15;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("in_mul_before_reset", int'(b_shift), 1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_outputs_zero("abort_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_done_after_abort", int'(done | busy), 0);
        end
        @(posedge clk); #1;

`ifdef MAC_EARLY_TERM_EN
        pa = {9}; pb = {0};
        run_job(1, 0, 1, 0, 5, 1, 0);
        pa = {9}; pb = {1};
        run_job(1, 0, 1, 9, 6, 1, 1);
`else
        pa = {9}; pb = {0};
        run_job(1, 0, 1, 0, 8, 1, 0);
        pa = {9}; pb = {1};
        run_job(1, 0, 1, 9, 8, 1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
